// File: rtl/register_bank_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_32_pkg
// Description : Shared constants and types for the 32-entry register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package register_bank_32_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    // Index of the register that may be tied to zero.
    localparam regIdx_t c_ZERO_REG_IDX = '0;

    // True when the index addresses the (possibly hardwired) zero register.
    function automatic logic isZeroReg(input regIdx_t idx);
        return (idx == c_ZERO_REG_IDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_bank_32_decoder.sv
`default_nettype none
// ============================================================================
// Module      : Decoder_32
// Description : 5-to-32 one-hot decoder with enable; all zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module Decoder_32
    import register_bank_32_pkg::*;
(
    input  logic                 enable,
    input  logic [REG_IDX_W-1:0] sel,
    output logic [REG_COUNT-1:0] out
);

    // Single hot bit at the selected position, only while enabled.
    always_comb begin
        out = '0;
        if (enable) begin
            out[sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_32
// Description : 32 x DATA_WIDTH register bank, one write port, two registered
//               read ports with same-edge write bypass, optional zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_32
    import register_bank_32_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  regWrite,
    input  logic [REG_IDX_W-1:0]  writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [REG_IDX_W-1:0]  readReg1,
    input  logic [REG_IDX_W-1:0]  readReg2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [REG_COUNT-1:0]  writeStrobe
);

    logic [DATA_WIDTH-1:0] r_regFile [REG_COUNT];
    logic [DATA_WIDTH-1:0] r_readData1;
    logic [DATA_WIDTH-1:0] r_readData2;
    logic [REG_COUNT-1:0]  r_writeStrobe;

    logic [REG_COUNT-1:0]  w_decoded;
    logic [REG_COUNT-1:0]  w_writeSel;
    logic [DATA_WIDTH-1:0] w_readNext1;
    logic [DATA_WIDTH-1:0] w_readNext2;

    Decoder_32 u_writeDecoder (
        .enable (regWrite),
        .sel    (writeReg),
        .out    (w_decoded)
    );

    // Effective write select: the zero register is never enabled when hardwired.
    always_comb begin
        w_writeSel = w_decoded;
        if (ZERO_HARDWIRED) begin
            w_writeSel[c_ZERO_REG_IDX] = 1'b0;
        end
    end

    // Read-port next values: zero register forced, otherwise bypass the
    // in-flight write so a same-edge read sees the new data.
    always_comb begin
        w_readNext1 = r_regFile[readReg1];
        w_readNext2 = r_regFile[readReg2];
        if (w_writeSel[readReg1]) begin
            w_readNext1 = writeData;
        end
        if (w_writeSel[readReg2]) begin
            w_readNext2 = writeData;
        end
        if (ZERO_HARDWIRED && isZeroReg(readReg1)) begin
            w_readNext1 = '0;
        end
        if (ZERO_HARDWIRED && isZeroReg(readReg2)) begin
            w_readNext2 = '0;
        end
    end

    // Register array, A/B read latches and write-strobe trace register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regFile[i] <= '0;
            end
            r_readData1   <= '0;
            r_readData2   <= '0;
            r_writeStrobe <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_writeSel[i]) begin
                    r_regFile[i] <= writeData;
                end
            end
            r_readData1   <= w_readNext1;
            r_readData2   <= w_readNext2;
            r_writeStrobe <= w_writeSel;
        end
    end

    assign readData1   = r_readData1;
    assign readData2   = r_readData2;
    assign writeStrobe = r_writeStrobe;

endmodule
`default_nettype wire

// File: tb/tb_register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank_32
// Description : Self-checking bench for register_bank_32: reference model with
//               per-cycle comparison plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_32;

    localparam int DW = 32;

    logic          clock;
    logic          reset_n;
    logic          regWrite;
    logic [4:0]    writeReg;
    logic [DW-1:0] writeData;
    logic [4:0]    readReg1;
    logic [4:0]    readReg2;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic [31:0]   writeStrobe;

    int total = 0;
    int bad   = 0;

    register_bank_32 #(
        .DATA_WIDTH     (DW),
        .ZERO_HARDWIRED (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .readData1   (readData1),
        .readData2   (readData2),
        .writeStrobe (writeStrobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [DW-1:0] mem [32];
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    logic [31:0]   expStrobe;

    function automatic logic [DW-1:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (regWrite && writeReg == idx) return writeData;
        return mem[idx];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            exp1      <= '0;
            exp2      <= '0;
            expStrobe <= '0;
        end else begin
            exp1      <= modelRead(readReg1);
            exp2      <= modelRead(readReg2);
            expStrobe <= (regWrite && writeReg != 5'd0) ? (32'd1 << writeReg) : 32'd0;
            if (regWrite && writeReg != 5'd0) mem[writeReg] <= writeData;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        total++;
        if (readData1 !== exp1) begin
            bad++;
            $display("FAIL model_rd1 t=%0t got=%h want=%h", $time, readData1, exp1);
        end
        total++;
        if (readData2 !== exp2) begin
            bad++;
            $display("FAIL model_rd2 t=%0t got=%h want=%h", $time, readData2, exp2);
        end
        total++;
        if (writeStrobe !== expStrobe) begin
            bad++;
            $display("FAIL model_strobe t=%0t got=%h want=%h", $time, writeStrobe, expStrobe);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Present one set of inputs for one rising edge; returns at the next falling edge.
    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        regWrite  = we;
        writeReg  = wr;
        writeData = wd;
        readReg1  = r1;
        readReg2  = r2;
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        readReg1  = '0;
        readReg2  = '0;
        repeat (3) @(negedge clock);
        check("reset_rd1", readData1, 32'h0);
        check("reset_rd2", readData2, 32'h0);
        check("reset_strobe", writeStrobe, 32'h0);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // Write r7, then read it back one cycle later.
        step(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
        check("wr7_strobe", writeStrobe, 32'h0000_0080);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        check("rd7", readData1, 32'h12345678);

        // Writes to the zero register are suppressed.
        step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        check("wr0_strobe", writeStrobe, 32'h0);
        check("wr0_rd1_same", readData1, 32'h0);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("rd0_p1", readData1, 32'h0);
        check("rd0_p2", readData2, 32'h0);

        // Same-edge bypass on port 2 while port 1 reads r7.
        step(1'b1, 5'd9, 32'hA5A5A5A5, 5'd7, 5'd9);
        check("bypass_rd2", readData2, 32'hA5A5A5A5);
        check("bypass_rd1_other", readData1, 32'h12345678);
        check("bypass_strobe", writeStrobe, 32'h0000_0200);
        // Bypass on both ports at once with identical indices.
        step(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
        check("bypass_both1", readData1, 32'h0BADF00D);
        check("bypass_both2", readData2, 32'h0BADF00D);

        // Hold: regWrite=0 must not change r31.
        step(1'b1, 5'd31, 32'h00000001, 5'd0, 5'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 5'd31, 32'h55, 5'd31, 5'd31);
        check("hold_r31_p1", readData1, 32'h00000001);
        check("hold_r31_p2", readData2, 32'h00000001);
        check("hold_strobe", writeStrobe, 32'h0);

        // Mid-run asynchronous reset after loading r5.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("pre_reset_r5", readData1, 32'hDEADBEEF);
        regWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'h77777777;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd1", readData1, 32'h0);
        check("async_rst_rd2", readData2, 32'h0);
        @(negedge clock);
        @(negedge clock);
        check("rst_strobe", writeStrobe, 32'h0);
        regWrite = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clock);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        check("post_rst_r5", readData1, 32'h0);
        check("post_rst_r7", readData2, 32'h0);

        // Sweep: fill r1..r31, read pairs (i, 31-i).
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            check("sweep_p1", readData1, 32'(i) * 32'h01010101);
            check("sweep_p2", readData2, 32'(31 - i) * 32'h01010101);
        end
        step(1'b0, 5'd0, 32'h0, 5'd31, 5'd16);
        check("sweep_lit31", readData1, 32'h1F1F1F1F);
        check("sweep_lit16", readData2, 32'h10101010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_bank_32.md
REGISTER_BANK_32 -- requirements
Module: register_bank_32

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each register and data port.
REQ-002 The block SHALL have parameter ZERO_HARDWIRED, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-003 Port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port regWrite, input, 1, write enable for the write port.
REQ-006 Port writeReg, input, 5, destination register index.
REQ-007 Port writeData, input, DATA_WIDTH, data to be written.
REQ-008 Port readReg1, input, 5, source index for read port 1.
REQ-009 Port readReg2, input, 5, source index for read port 2.
REQ-010 Port readData1, output, DATA_WIDTH, registered read port 1 value (A latch).
REQ-011 Port readData2, output, DATA_WIDTH, registered read port 2 value (B latch).
REQ-012 Port writeStrobe, output, 32, registered one-hot copy of the last accepted write select, for debug/trace.

Function
REQ-013 Storage SHALL be 32 registers of DATA_WIDTH bits, indexed 0..31.
REQ-014 On a rising edge with regWrite=1, register[writeReg] SHALL take writeData, except index 0 when ZERO_HARDWIRED=1.
REQ-015 With regWrite=0, no register SHALL change.
REQ-016 Write selection SHALL be one-hot: exactly one register enabled when regWrite=1, none otherwise.
REQ-017 On every rising edge, readData1 SHALL load the value of register[readReg1] and readData2 the value of register[readReg2]; read latency is one cycle.
REQ-018 Same-edge bypass: if regWrite=1 and readRegN==writeReg (and not the hardwired index 0), readDataN SHALL load writeData, not the old register value.
REQ-019 Reads of index 0 with ZERO_HARDWIRED=1 SHALL load 0 regardless of any write to index 0.
REQ-020 Both read ports SHALL be independent; readReg1==readReg2 SHALL give identical outputs.
REQ-021 writeStrobe SHALL load the one-hot write select each edge (all zero when regWrite=0 or a write to hardwired index 0 is suppressed).
REQ-022 No X SHALL propagate to outputs after reset for any index 0..31.

Reset
REQ-023 While reset_n=0, all 32 registers, readData1, readData2 and writeStrobe SHALL be 0, asynchronously, regardless of clock.
REQ-024 A write presented on the same edge reset_n is low SHALL be discarded.
REQ-025 Reset asserted mid-operation SHALL clear state immediately; the first edge after deassertion SHALL operate normally.

Structure
REQ-026 A shared package SHALL hold REG_COUNT=32, REG_IDX_W=5 and the zero-register index constant.
REQ-027 One-hot write select SHALL be produced by instantiating the existing Decoder_32 block (enable=regWrite, sel=writeReg); no other sub-module.
REQ-028 Register array and A/B latches SHALL be in one always block per clock domain element group; no latches, no internal tristates.

Verification
REQ-029 Reset: drive reset_n=0 mid-run after writing 0xDEADBEEF to r5 -> readData1/2=0, writeStrobe=0; after release, read r5 -> 0.
REQ-030 Write/read: write 0x12345678 to r7, next cycle readReg1=7 -> readData1=0x12345678 one edge later; writeStrobe bit 7 set on the write edge.
REQ-031 Zero register: write 0xFFFFFFFF to r0, read r0 on both ports -> 0; writeStrobe=0.
REQ-032 Bypass: same edge regWrite=1, writeReg=9, writeData=0xA5A5A5A5, readReg2=9 -> readData2=0xA5A5A5A5 after that edge.
REQ-033 No-write hold: preload r31=0x00000001, drive regWrite=0 with writeReg=31, writeData=0x55 for 10 cycles -> r31 still reads 0x00000001.
REQ-034 Sweep: write index i with value i*0x01010101 for i=1..31, read all pairs (i, 31-i) -> both ports match expected values.
